// File: rtl/hist_pkg.sv
// Shared definitions for the event histogram: display codes from the scan
// controller and the argmax scan state encoding.
package hist_pkg;

  localparam logic [2:0] CODE_NONE   = 3'd0;
  localparam logic [2:0] CODE_FDOOR  = 3'd1;
  localparam logic [2:0] CODE_RDOOR  = 3'd2;
  localparam logic [2:0] CODE_FIRE   = 3'd3;
  localparam logic [2:0] CODE_WIN    = 3'd4;
  localparam logic [2:0] CODE_TLOW   = 3'd5;
  localparam logic [2:0] CODE_THIGH  = 3'd6;
  localparam logic [2:0] CODE_UNUSED = 3'd7;

  localparam int NUM_CODES = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } hist_state_e;

  // Codes 1..6 are real events; 0 (none) and 7 (unused) are never counted.
  function automatic logic is_event(input logic [2:0] code);
    return (code != CODE_NONE) && (code != CODE_UNUSED);
  endfunction

endpackage

// File: rtl/event_histogram_if.sv
// Signal bundle between the scan controller / panel logic and the histogram.
interface event_histogram_if
  import hist_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TOT_W = 11
);
  logic [2:0]       code_in;
  logic             code_en;
  logic             clr;
  logic [2:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic [TOT_W-1:0] total;
  // Scan request/response: snap_req is taken only on a cycle where the engine
  // is not busy (no queuing); each accepted request produces exactly one
  // single-cycle done pulse, with top_code/top_count valid from that cycle on.
  logic             snap_req;
  logic             busy;
  logic             done;
  logic [2:0]       top_code;
  logic [CNT_W-1:0] top_count;
  hist_state_e      state;

  modport master (
    output code_in, code_en, clr, rd_sel, snap_req,
    input  rd_data, total, busy, done, top_code, top_count, state
  );

  modport slave (
    input  code_in, code_en, clr, rd_sel, snap_req,
    output rd_data, total, busy, done, top_code, top_count, state
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/event_histogram.sv
// Per-event saturating occurrence counters with registered readout and a
// snapshot-based argmax scan reporting the most frequent event.
module event_histogram
  import hist_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int TOT_W = 11
) (
  input  logic Clk,
  input  logic Rst,
  event_histogram_if.slave bus
);

  logic             ev_valid;
  logic [CNT_W-1:0] cnt_q  [1:NUM_CODES];
  logic [CNT_W-1:0] snap_d [1:NUM_CODES];
  logic [CNT_W-1:0] snap_q [1:NUM_CODES];
  logic [TOT_W-1:0] total_q;

  hist_state_e      state_q;
  logic [2:0]       idx_q;
  logic [2:0]       best_code_q;
  logic [CNT_W-1:0] best_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       top_code_q;
  logic [CNT_W-1:0] top_cnt_q;
  logic [CNT_W-1:0] rd_data_q;
  logic [CNT_W-1:0] rd_val;
  logic [CNT_W-1:0] cur_cnt;
  logic             gt;

  assign ev_valid = bus.code_en && is_event(bus.code_in);

  for (genvar i = 1; i <= NUM_CODES; i++) begin : g_cnt
    logic inc;
    assign inc = ev_valid && (bus.code_in == 3'(i));

    sat_counter #(.W(CNT_W)) u_cnt (
      .Clk (Clk),
      .Rst (Rst),
      .clr (bus.clr),
      .inc (inc),
      .q   (cnt_q[i])
    );

    // Value the counter holds after this edge, so a snapshot includes the
    // event arriving together with snap_req.
    assign snap_d[i] = bus.clr ? '0 :
                       (inc && !(&cnt_q[i])) ? cnt_q[i] + 1'b1 : cnt_q[i];
  end

  sat_counter #(.W(TOT_W)) u_total (
    .Clk (Clk),
    .Rst (Rst),
    .clr (bus.clr),
    .inc (ev_valid),
    .q   (total_q)
  );

  always_comb begin
    rd_val  = '0;
    cur_cnt = '0;
    for (int k = 1; k <= NUM_CODES; k++) begin
      if (bus.rd_sel == 3'(k)) rd_val = cnt_q[k];
      if (idx_q == 3'(k))      cur_cnt = snap_q[k];
    end
  end

  // Strict compare keeps the lowest code on ties.
  assign gt = cur_cnt > best_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      best_code_q <= CODE_NONE;
      best_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      top_code_q  <= CODE_NONE;
      top_cnt_q   <= '0;
      rd_data_q   <= '0;
      for (int k = 1; k <= NUM_CODES; k++) snap_q[k] <= '0;
    end else begin
      done_q    <= 1'b0;
      rd_data_q <= rd_val;
      case (state_q)
        IDLE, DONE: begin
          if (bus.snap_req) begin
            for (int k = 1; k <= NUM_CODES; k++) snap_q[k] <= snap_d[k];
            idx_q       <= 3'd1;
            best_code_q <= CODE_NONE;
            best_cnt_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= SCAN;
          end else begin
            state_q <= IDLE;
          end
        end
        SCAN: begin
          if (gt) begin
            best_code_q <= idx_q;
            best_cnt_q  <= cur_cnt;
          end
          if (idx_q == 3'(NUM_CODES)) begin
            top_code_q <= gt ? idx_q : best_code_q;
            top_cnt_q  <= gt ? cur_cnt : best_cnt_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= DONE;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.total     = total_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.top_code  = top_code_q;
  assign bus.top_count = top_cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_event_histogram.sv
// Directed bench for event_histogram: counting, readout, clear, saturation
// and argmax scan timing, with a done-pulse scoreboard.
module tb_event_histogram;
  import hist_pkg::*;

  localparam int CW = 8;
  localparam int TW = 11;

  logic clk;
  logic Rst;

  event_histogram_if #(.CNT_W(CW), .TOT_W(TW)) bus ();
  event_histogram_if #(.CNT_W(4),  .TOT_W(TW)) bus_s ();

  event_histogram #(.CNT_W(CW), .TOT_W(TW)) u_dut (
    .Clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  event_histogram #(.CNT_W(4), .TOT_W(TW)) u_small (
    .Clk (clk),
    .Rst (Rst),
    .bus (bus_s)
  );

  assign bus_s.code_in  = bus.code_in;
  assign bus_s.code_en  = bus.code_en;
  assign bus_s.clr      = bus.clr;
  assign bus_s.rd_sel   = bus.rd_sel;
  assign bus_s.snap_req = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [CW+2:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  // driver tasks
  task automatic feed(input logic [2:0] c);
    bus.code_in = c;
    tick();
    bus.code_in = CODE_NONE;
  endtask

  task automatic read_check(input logic [2:0] sel, input int exp, input string name);
    bus.rd_sel = sel;
    tick();
    check(name, 32'(bus.rd_data), exp);
  endtask

  task automatic run_scan(input logic [2:0] ec, input logic [CW-1:0] ecnt,
                          input int req_at, input int clr_at, input int rst_at);
    logic [2:0]    prev_code;
    logic [CW-1:0] prev_cnt;
    prev_code = bus.top_code;
    prev_cnt  = bus.top_count;
    if (rst_at == 0) exp_q.push_back({ec, ecnt});
    bus.snap_req = 1'b1;
    tick();
    bus.snap_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check("scan_busy", 32'(bus.busy), 1);
      check("scan_no_done", 32'(bus.done), 0);
      check("scan_top_held", 32'({bus.top_code, bus.top_count}), 32'({prev_code, prev_cnt}));
      bus.snap_req = (k == req_at);
      bus.clr      = (k == clr_at);
      Rst          = (k == rst_at);
      tick();
      bus.snap_req = 1'b0;
      bus.clr      = 1'b0;
      if (k == rst_at) begin
        Rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_top", 32'({bus.top_code, bus.top_count}), 0);
        check("abort_state", 32'(bus.state), 32'(IDLE));
        return;
      end
    end
    check("scan_done", 32'(bus.done), 1);
    check("scan_done_busy", 32'(bus.busy), 0);
    tick();
    check("done_one_cycle", 32'(bus.done), 0);
  endtask

  // scoreboard monitor: every done pulse must match the oldest expected result
  initial begin
    logic [CW+2:0] e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done top_code=%0d top_count=%0d expected no done",
                   bus.top_code, bus.top_count);
        end else begin
          e = exp_q.pop_front();
          if ({bus.top_code, bus.top_count} !== e) begin
            errors++;
            $display("FAIL top_result actual=%0d/%0d expected=%0d/%0d",
                     bus.top_code, bus.top_count, e[CW+2:CW], e[CW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] seq [13];
    int         exp_rd [8];
    seq = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd2, 3'd1, 3'd3, 3'd5, 3'd1, 3'd2, 3'd4, 3'd3};
    exp_rd = '{0, 4, 3, 3, 2, 1, 0, 0};
    Rst = 1'b1;
    bus.code_in = CODE_NONE;
    bus.code_en = 1'b1;
    bus.clr = 1'b0;
    bus.snap_req = 1'b0;
    bus.rd_sel = 3'd0;

    // reset state
    do_reset();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_top", 32'({bus.top_code, bus.top_count}), 0);
    check("rst_total", 32'(bus.total), 0);
    check("rst_rd", 32'(bus.rd_data), 0);
    check("rst_state", 32'(bus.state), 32'(IDLE));

    // scan sequence counting and readout
    for (int i = 0; i < 13; i++) feed(seq[i]);
    check("seq_total", 32'(bus.total), 13);
    for (int s = 0; s < 8; s++) read_check(3'(s), exp_rd[s], "seq_rd");

    // code_en low blocks counting
    bus.code_en = 1'b0;
    feed(3'd1);
    bus.code_en = 1'b1;
    check("en_low_total", 32'(bus.total), 13);

    // basic argmax
    do_reset();
    for (int i = 0; i < 3; i++) begin
      feed(3'd1); feed(3'd2); feed(3'd3);
    end
    feed(3'd1);
    run_scan(3'd1, 8'd4, 0, 0, 0);

    // tie resolves to lowest code
    do_reset();
    for (int i = 0; i < 5; i++) begin
      feed(3'd3); feed(3'd2);
    end
    run_scan(3'd2, 8'd5, 0, 0, 0);

    // all zero
    do_reset();
    run_scan(3'd0, 8'd0, 0, 0, 0);

    // snap_req while busy is ignored
    do_reset();
    feed(3'd3); feed(3'd3);
    run_scan(3'd3, 8'd2, 2, 0, 0);
    repeat (10) tick();

    // clr mid-scan: scan reports pre-clear snapshot
    do_reset();
    feed(3'd5); feed(3'd5); feed(3'd5); feed(3'd4); feed(3'd4);
    run_scan(3'd5, 8'd3, 0, 2, 0);
    check("midclr_total", 32'(bus.total), 0);
    read_check(3'd5, 0, "midclr_rd5");

    // clr wins over a simultaneous event
    do_reset();
    feed(3'd4); feed(3'd4); feed(3'd1);
    check("preclr_total", 32'(bus.total), 3);
    bus.code_in = 3'd4;
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    bus.code_in = CODE_NONE;
    check("clr_total", 32'(bus.total), 0);
    read_check(3'd4, 0, "clr_rd4");
    read_check(3'd1, 0, "clr_rd1");
    feed(3'd4);
    check("postclr_total", 32'(bus.total), 1);

    // saturation on the narrow instance, ignored codes 0 and 7
    do_reset();
    repeat (20) feed(3'd6);
    repeat (5) feed(3'd0);
    repeat (5) feed(3'd7);
    bus.rd_sel = 3'd6;
    tick();
    check("sat_small_rd6", 32'(bus_s.rd_data), 15);
    check("sat_big_rd6", 32'(bus.rd_data), 20);
    check("sat_small_total", 32'(bus_s.total), 20);
    check("sat_big_total", 32'(bus.total), 20);

    // reset aborts a scan: no done, top cleared
    do_reset();
    feed(3'd1); feed(3'd1);
    run_scan(3'd1, 8'd2, 0, 0, 0);
    feed(3'd2);
    run_scan(3'd0, 8'd0, 0, 0, 3);
    repeat (10) tick();

    check("pending_done", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
